// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the RPN CPU execution scheduler: run modes and FSM states.
package cpu_step_ctrl_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SLOW  = 2'd0,
        MODE_TURBO = 2'd1,
        MODE_STEP  = 2'd2,
        MODE_HALT  = 2'd3
    } mode_e;

    typedef enum logic [STATE_W-1:0] {
        S_RUN  = 2'd0,
        S_BRK  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Per-mode execute request before breakpoint/FSM gating.
    function automatic logic mode_req(input mode_e mode, input logic tick, input logic step);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_SLOW:  r = tick;
            MODE_TURBO: r = 1'b1;
            MODE_STEP:  r = step;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_tick_prescaler.sv
// Free-running 0..CNT_MAX counter producing a one-clk tick when the count is zero.
module tick_prescaler #(
    parameter int unsigned CNT_MAX = 12500000,
    parameter int unsigned CNT_W   = 24
) (
    input  logic clk,
    input  logic Reset,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution scheduler: derives the CPU go enable from mode, step and breakpoint,
// and counts executed instructions for the debug display.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned CNT_MAX = 12500000,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned IP_W    = 8,
    parameter int unsigned ICNT_W  = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [1:0]        mode_sel,
    input  logic              step_pulse,
    input  logic              bp_en,
    input  logic [IP_W-1:0]   bp_addr,
    input  logic [IP_W-1:0]   ip,
    input  logic              clr_icnt,
    output logic              go,
    output logic              halted,
    output logic [1:0]        state,
    output logic [ICNT_W-1:0] icnt
);

    mode_e             mode;
    state_e            state_q;
    state_e            state_d;
    logic              tick;
    logic              req;
    logic              bp_hit;
    logic              skip_q;
    logic              skip_set;
    logic [ICNT_W-1:0] icnt_q;

    tick_prescaler #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .tick  (tick)
    );

    assign mode   = mode_e'(mode_sel);
    assign req    = mode_req(mode, tick, step_pulse);
    assign bp_hit = bp_en & (ip == bp_addr) & ~skip_q;

    // go is combinational so TURBO can issue on every clock without a bubble.
    always_comb begin
        state_d  = state_q;
        go       = 1'b0;
        skip_set = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mode == MODE_HALT) begin
                    state_d = S_HOLD;
                end else if (req && bp_hit) begin
                    state_d = S_BRK;
                end else begin
                    go = req;
                end
            end
            S_BRK: begin
                if (step_pulse) begin
                    go       = 1'b1;
                    skip_set = 1'b1;
                    state_d  = S_RUN;
                end else if (!bp_en) begin
                    state_d = S_RUN;
                end
            end
            S_HOLD: begin
                if (mode != MODE_HALT) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (Reset) begin
            go = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // skip lets the breakpoint instruction run once on resume without re-trapping.
    always_ff @(posedge clk) begin
        if (Reset) begin
            skip_q <= 1'b0;
        end else if (skip_set) begin
            skip_q <= 1'b1;
        end else if (go || (ip != bp_addr)) begin
            skip_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset || clr_icnt) begin
            icnt_q <= '0;
        end else if (go && !(&icnt_q)) begin
            icnt_q <= icnt_q + ICNT_W'(1);
        end
    end

    assign halted = (state_q == S_BRK) | (mode == MODE_HALT);
    assign state  = state_q;
    assign icnt   = icnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a small prescaler; the bench models ip as the CPU would.
module tb_cpu_step_ctrl;

    localparam int unsigned IP_W   = 8;
    localparam int unsigned ICNT_W = 16;

    logic              clk = 1'b0;
    logic              Reset;
    logic [1:0]        mode_sel;
    logic              step_pulse;
    logic              bp_en;
    logic [IP_W-1:0]   bp_addr;
    logic [IP_W-1:0]   ip;
    logic              clr_icnt;
    logic              go;
    logic              halted;
    logic [1:0]        state;
    logic [ICNT_W-1:0] icnt;

    int checks = 0;
    int errors = 0;
    logic last_go;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .CNT_MAX (3),
        .CNT_W   (4),
        .IP_W    (IP_W),
        .ICNT_W  (ICNT_W)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .mode_sel   (mode_sel),
        .step_pulse (step_pulse),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .ip         (ip),
        .clr_icnt   (clr_icnt),
        .go         (go),
        .halted     (halted),
        .state      (state),
        .icnt       (icnt)
    );

    // One clock: capture go before the edge, advance ip like the CPU does, settle.
    task automatic cyc();
        #1;
        last_go = go;
        @(posedge clk);
        #1;
        if (last_go) ip = ip + 8'd1;
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        ip    = 8'd0;
        #1;
    endtask

    task automatic test_reset();
        logic exp_go;
        logic [ICNT_W-1:0] exp_icnt;
        Reset = 1'b1; mode_sel = 2'd0; step_pulse = 1'b0; bp_en = 1'b0;
        bp_addr = 8'd0; ip = 8'd0; clr_icnt = 1'b0;
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL reset_go0 go=%b exp=0", go); end
        cyc();
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL reset_go1 go=%b exp=0", go); end
        checks++;
        if (state !== 2'd0 || icnt !== 16'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_state state=%0d icnt=%0d halted=%b exp=0/0/0", state, icnt, halted);
        end
        cyc();
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            exp_go   = ((k % 4) == 0);
            exp_icnt = 16'((k + 3) / 4);
            checks++;
            if (go !== exp_go) begin errors++; $display("FAIL slow_go[%0d] go=%b exp=%b", k, go, exp_go); end
            checks++;
            if (icnt !== exp_icnt) begin errors++; $display("FAIL slow_icnt[%0d] icnt=%0d exp=%0d", k, icnt, exp_icnt); end
            cyc();
        end
        checks++;
        if (icnt !== 16'd3) begin errors++; $display("FAIL slow_icnt_end icnt=%0d exp=3", icnt); end
    endtask

    task automatic test_turbo_bp();
        mode_sel = 2'd1; bp_en = 1'b1; bp_addr = 8'd5;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (go !== 1'b1) begin errors++; $display("FAIL turbo_go[%0d] go=%b exp=1", k, go); end
            cyc();
        end
        checks++;
        if (go !== 1'b0 || ip !== 8'd5) begin errors++; $display("FAIL bp_trap_go go=%b ip=%0d exp=0/5", go, ip); end
        cyc();
        checks++;
        if (state !== 2'd1 || halted !== 1'b1 || icnt !== 16'd5 || go !== 1'b0) begin
            errors++; $display("FAIL bp_brk state=%0d halted=%b icnt=%0d go=%b exp=1/1/5/0", state, halted, icnt, go);
        end
    endtask

    task automatic test_step_resume();
        step_pulse = 1'b1;
        #1;
        checks++;
        if (go !== 1'b1) begin errors++; $display("FAIL resume_go go=%b exp=1", go); end
        cyc();
        step_pulse = 1'b0;
        #1;
        checks++;
        if (ip !== 8'd6 || state !== 2'd0 || go !== 1'b1) begin
            errors++; $display("FAIL resume_run ip=%0d state=%0d go=%b exp=6/0/1", ip, state, go);
        end
        cyc();
        cyc();
        ip = 8'd5;
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL retrap_go go=%b exp=0", go); end
        cyc();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL retrap_state state=%0d exp=1", state); end
    endtask

    task automatic test_bp_drop();
        bp_en = 1'b0;
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL drop_go go=%b exp=0", go); end
        cyc();
        checks++;
        if (state !== 2'd0 || go !== 1'b1 || ip !== 8'd5) begin
            errors++; $display("FAIL drop_run state=%0d go=%b ip=%0d exp=0/1/5", state, go, ip);
        end
        // Trap again, then release with step in HALT mode together with bp_en low.
        bp_en = 1'b1;
        ip = 8'd5;
        #1;
        cyc();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL trap3_state state=%0d exp=1", state); end
        mode_sel = 2'd3; bp_en = 1'b0; step_pulse = 1'b1;
        #1;
        checks++;
        if (go !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_step go=%b halted=%b exp=1/1", go, halted);
        end
        cyc();
        step_pulse = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || go !== 1'b0 || halted !== 1'b1 || ip !== 8'd6) begin
            errors++; $display("FAIL halt_step_run state=%0d go=%b halted=%b ip=%0d exp=0/0/1/6", state, go, halted, ip);
        end
        cyc();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL halt_hold state=%0d exp=2", state); end
    endtask

    task automatic test_step_mode();
        mode_sel = 2'd2; bp_en = 1'b0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 10; j++) begin
                step_pulse = (j == 0);
                #1;
                checks++;
                if (go !== (j == 0)) begin errors++; $display("FAIL step_go[%0d,%0d] go=%b exp=%b", p, j, go, (j == 0)); end
                cyc();
            end
        end
        step_pulse = 1'b0;
        checks++;
        if (icnt !== 16'd3 || ip !== 8'd3) begin errors++; $display("FAIL step_icnt icnt=%0d ip=%0d exp=3/3", icnt, ip); end
        mode_sel = 2'd3;
        #1;
        checks++;
        if (go !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL hold_enter go=%b halted=%b exp=0/1", go, halted); end
        cyc();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL hold_state state=%0d exp=2", state); end
        for (int k = 0; k < 80; k++) begin
            step_pulse = (k % 7 == 0);
            #1;
            checks++;
            if (go !== 1'b0) begin errors++; $display("FAIL hold_go[%0d] go=%b exp=0", k, go); end
            cyc();
        end
        step_pulse = 1'b0;
        mode_sel = 2'd1;
        #1;
        checks++;
        if (state !== 2'd2 || go !== 1'b0) begin errors++; $display("FAIL hold_exit state=%0d go=%b exp=2/0", state, go); end
        cyc();
        checks++;
        if (state !== 2'd0 || go !== 1'b1 || icnt !== 16'd3) begin
            errors++; $display("FAIL hold_resume state=%0d go=%b icnt=%0d exp=0/1/3", state, go, icnt);
        end
    endtask

    task automatic test_icnt_sat();
        logic [IP_W-1:0] ip_before;
        mode_sel = 2'd1; bp_en = 1'b0;
        do_reset();
        for (int k = 0; k < 65534; k++) cyc();
        checks++;
        if (icnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre icnt=%h exp=fffe", icnt); end
        cyc();
        checks++;
        if (icnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max icnt=%h exp=ffff", icnt); end
        cyc();
        checks++;
        if (icnt !== 16'hFFFF || go !== 1'b1) begin errors++; $display("FAIL sat_hold icnt=%h go=%b exp=ffff/1", icnt, go); end
        clr_icnt = 1'b1;
        #1;
        cyc();
        clr_icnt = 1'b0;
        #1;
        checks++;
        if (icnt !== 16'd0) begin errors++; $display("FAIL clr_prio icnt=%0d exp=0", icnt); end
        cyc();
        checks++;
        if (icnt !== 16'd1) begin errors++; $display("FAIL clr_count icnt=%0d exp=1", icnt); end
        ip_before = ip;
        Reset = 1'b1;
        #1;
        checks++;
        if (go !== 1'b0) begin errors++; $display("FAIL mid_reset_go go=%b exp=0", go); end
        cyc();
        Reset = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || icnt !== 16'd0 || ip !== ip_before || go !== 1'b1) begin
            errors++; $display("FAIL mid_reset_clr state=%0d icnt=%0d ip=%0d go=%b exp=0/0/%0d/1", state, icnt, ip, go, ip_before);
        end
    endtask

    initial begin
        test_reset();
        test_turbo_bp();
        test_step_resume();
        test_bp_drop();
        test_step_mode();
        test_icnt_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
